// File: rtl/run_controller.sv
// Run controller: sequences CPU reset, run and stop.
// Runs end on halt, cycle timeout or pc stall.
module run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 10000,
  parameter int unsigned STALL_LIMIT  = 8,
  parameter int unsigned PC_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  localparam int unsigned RST_N =
    (RESET_CYCLES == 0) ? 1 : RESET_CYCLES;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_HALT  = 2'b01;
  localparam logic [1:0] C_TOUT  = 2'b10;
  localparam logic [1:0] C_STALL = 2'b11;

  state_t            state_q, state_d;
  logic [31:0]       rst_cnt_q, rst_cnt_d;
  logic [31:0]       stall_q, stall_d;
  logic [PC_W-1:0]   prev_q, prev_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [1:0]        cause_q, cause_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              cpu_en_q, cpu_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  cyc_inc;
  logic              tout_hit;
  logic              pc_eq;
  logic              stall_hit;

  always_comb begin
    cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    // compare wide so a small counter never aliases a large limit
    tout_hit = (MAX_CYCLES != 0) &&
      ((64'(cyc_q) + 64'd1) == 64'(MAX_CYCLES));
    pc_eq = !first_q && (pc == prev_q);
    stall_hit = (STALL_LIMIT != 0) && pc_eq &&
      ((stall_q + 32'd1) == 32'(STALL_LIMIT));
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    stall_d   = stall_q;
    prev_d    = prev_q;
    first_d   = first_q;
    cyc_d     = cyc_q;
    cause_d   = cause_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RESET;
          cyc_d     = '0;
          cause_d   = C_NONE;
          rst_cnt_d = '0;
        end
      end
      S_RESET: begin
        if ((rst_cnt_q + 32'd1) == 32'(RST_N)) begin
          state_d = S_RUN;
          first_d = 1'b1;
          stall_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        cyc_d   = cyc_inc;
        first_d = 1'b0;
        if (first_q) begin
          prev_d  = pc;
          stall_d = '0;
        end else if (pc_eq) begin
          stall_d = stall_q + 32'd1;
        end else begin
          stall_d = '0;
          prev_d  = pc;
        end
        if (halt) begin
          state_d = S_DONE;
          cause_d = C_HALT;
        end else if (tout_hit) begin
          state_d = S_DONE;
          cause_d = C_TOUT;
        end else if (stall_hit) begin
          state_d = S_DONE;
          cause_d = C_STALL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cpu_reset_d = (state_d == S_IDLE) ||
                  (state_d == S_RESET);
    cpu_en_d    = (state_d == S_RUN);
    busy_d      = (state_d == S_RESET) ||
                  (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      stall_q     <= '0;
      prev_q      <= '0;
      first_q     <= 1'b0;
      cyc_q       <= '0;
      cause_q     <= C_NONE;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_q     <= stall_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      cyc_q       <= cyc_d;
      cause_q     <= cause_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign cpu_en    = cpu_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cause     = cause_q;
  assign cycles    = cyc_q;

endmodule
